bitscan_encoder: RTL and testbench

BITSCAN_ENCODER -- requirements
Module: bitscan_encoder

---
 rtl/bitscan_pkg.sv | 17 +
 rtl/bitscan_prio_enc.sv | 41 ++++
 rtl/bitscan_encoder.sv | 83 ++++++++
 tb/tb_bitscan_encoder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitscan_pkg.sv
// Shared definitions for the bit-scan encoder: scanner state encoding and the
// index-width helper used by the encoder and its priority encoder.
package bitscan_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SCAN = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        SCAN = ST_SCAN
    } state_t;

    function automatic int idx_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bitscan_prio_enc.sv
// Combinational priority encoder over the pending vector: selects the lowest
// (or highest) set bit and reports whether any / more than one bit is set.
module prio_enc
    import bitscan_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    localparam int IDX_W    = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign any   = |vec;
    assign multi = |(vec & (vec - WIDTH'(1)));

    // The last matching iteration wins, so the scan direction sets the priority.
    if (MSB_FIRST != 0) begin : g_msb
        always_comb begin
            idx = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end
    end else begin : g_lsb
        always_comb begin
            idx = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/bitscan_encoder.sv
// Accepts a vector and emits the index of each set bit, one beat per cycle in
// priority order; an all-zero vector yields a single "none" beat.
module bitscan_encoder
    import bitscan_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    localparam int IDX_W    = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none
);

    state_t           state_q, state_next;
    logic [WIDTH-1:0] pending_q, pending_next;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_multi;
    logic             scanning;

    prio_enc #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio (
        .vec   (pending_q),
        .idx   (enc_idx),
        .any   (enc_any),
        .multi (enc_multi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_next;
            pending_q <= pending_next;
        end
    end

    always_comb begin
        state_next   = state_q;
        pending_next = pending_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pending_next = in_vec;
                    state_next   = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    pending_next = pending_q & ~(WIDTH'(1) << enc_idx);
                    if (!enc_multi) begin
                        state_next   = IDLE;
                        pending_next = '0;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
            end
        endcase
    end

    // Outputs depend only on registered state, never on the in_* inputs.
    assign scanning  = (state_q == SCAN);
    assign in_ready  = !scanning;
    assign out_valid = scanning;
    assign out_idx   = scanning ? enc_idx : '0;
    assign out_last  = scanning && !enc_multi;
    assign out_none  = scanning && !enc_any;

endmodule

// File: tb/tb_bitscan_encoder.sv
// Drives an LSB-first and an MSB-first encoder with identical stimulus and
// compares both against a queue-based model of the expected beat sequence.
module tb_bitscan_encoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       in_ready0, out_valid0, out_last0, out_none0;
    logic [2:0] out_idx0;
    logic       in_ready1, out_valid1, out_last1, out_none1;
    logic [2:0] out_idx1;

    int tests;
    int fails;

    // Expected beats per DUT; -1 stands for the "none" beat of an all-zero vector.
    int q0[$];
    int q1[$];
    bit mdl_scan;

    bitscan_encoder #(.WIDTH(8), .MSB_FIRST(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_vec    (in_vec),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_idx   (out_idx0),
        .out_last  (out_last0),
        .out_none  (out_none0)
    );

    bitscan_encoder #(.WIDTH(8), .MSB_FIRST(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_vec    (in_vec),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_idx   (out_idx1),
        .out_last  (out_last1),
        .out_none  (out_none1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] act_out(input int d);
        if (d == 0) return {out_valid0, in_ready0, out_idx0, out_last0, out_none0};
        return {out_valid1, in_ready1, out_idx1, out_last1, out_none1};
    endfunction

    function automatic logic [6:0] exp_out(input int d);
        int  head;
        int  sz;
        logic none;
        if (!mdl_scan) return {1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
        head = (d == 0) ? q0[0] : q1[0];
        sz   = (d == 0) ? q0.size() : q1.size();
        none = (head < 0);
        return {1'b1, 1'b0, none ? 3'd0 : 3'(head), sz == 1, none};
    endfunction

    function automatic void mdl_load(input logic [7:0] v);
        q0.delete();
        q1.delete();
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                q0.push_back(i);
                q1.push_front(i);
            end
        end
        if (q0.size() == 0) begin
            q0.push_back(-1);
            q1.push_back(-1);
        end
        mdl_scan = 1'b1;
    endfunction

    function automatic void mdl_reset();
        q0.delete();
        q1.delete();
        mdl_scan = 1'b0;
    endfunction

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            if (!mdl_scan) begin
                if (in_valid) mdl_load(in_vec);
            end else if (out_ready) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
                if (q0.size() == 0) mdl_scan = 1'b0;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        mdl_reset();
        #2;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (act_out(d) !== exp_out(d)) begin
                fails++;
                $display("[TB] FAIL reset dut%0d: got %b expected %b", d, act_out(d), exp_out(d));
            end
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_two_bits();
        in_valid  = 1'b1;
        in_vec    = 8'b1000_0001;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_idx0 !== 3'd0 || out_last0 !== 1'b0 || out_idx1 !== 3'd7) begin
            fails++;
            $display("[TB] FAIL two_bits_first: got idx0=%0d last0=%b idx1=%0d expected 0 0 7",
                     out_idx0, out_last0, out_idx1);
        end
        for (int c = 0; c < 3; c++) begin
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (act_out(d) !== exp_out(d)) begin
                    fails++;
                    $display("[TB] FAIL two_bits dut%0d cyc%0d: got %b expected %b", d, c, act_out(d), exp_out(d));
                end
            end
            step();
        end
    endtask

    task automatic test_zero_vector();
        in_valid  = 1'b1;
        in_vec    = 8'h00;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_none0 !== 1'b1 || out_last0 !== 1'b1 || out_idx0 !== 3'd0 || out_valid0 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL zero_beat: got none=%b last=%b idx=%0d valid=%b expected 1 1 0 1",
                     out_none0, out_last0, out_idx0, out_valid0);
        end
        for (int c = 0; c < 2; c++) begin
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (act_out(d) !== exp_out(d)) begin
                    fails++;
                    $display("[TB] FAIL zero dut%0d cyc%0d: got %b expected %b", d, c, act_out(d), exp_out(d));
                end
            end
            step();
        end
    endtask

    task automatic test_stall();
        int beats;
        int c;
        in_valid  = 1'b1;
        in_vec    = 8'hFF;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        beats    = 0;
        c        = 0;
        while (mdl_scan && c < 40) begin
            out_ready = (c % 3 == 0);
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (act_out(d) !== exp_out(d)) begin
                    fails++;
                    $display("[TB] FAIL stall dut%0d cyc%0d: got %b expected %b", d, c, act_out(d), exp_out(d));
                end
            end
            if (out_ready && out_valid0) beats++;
            step();
            c++;
        end
        tests++;
        if (beats != 8 || mdl_scan) begin
            fails++;
            $display("[TB] FAIL stall_beats: got %0d beats (done=%b) expected 8", beats, !mdl_scan);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_scan();
        in_valid  = 1'b1;
        in_vec    = 8'hF0;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        mdl_reset();
        tests++;
        if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || in_ready0 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_mid_scan: got valid0=%b valid1=%b ready0=%b expected 0 0 1",
                     out_valid0, out_valid1, in_ready0);
        end
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (act_out(d) !== exp_out(d)) begin
                    fails++;
                    $display("[TB] FAIL after_reset dut%0d cyc%0d: got %b expected %b", d, c, act_out(d), exp_out(d));
                end
            end
            step();
        end
    endtask

    task automatic test_onehot_ignore();
        in_valid  = 1'b1;
        in_vec    = 8'b0001_0000;
        out_ready = 1'b0;
        step();
        in_vec = 8'hAA;
        for (int c = 0; c < 4; c++) begin
            out_ready = (c == 3);
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (act_out(d) !== exp_out(d)) begin
                    fails++;
                    $display("[TB] FAIL onehot dut%0d cyc%0d: got %b expected %b", d, c, act_out(d), exp_out(d));
                end
            end
            tests++;
            if (out_idx0 !== 3'd4 || out_idx1 !== 3'd4 || out_last0 !== 1'b1 || out_none0 !== 1'b0) begin
                fails++;
                $display("[TB] FAIL onehot_beat cyc%0d: got idx0=%0d idx1=%0d last=%b none=%b expected 4 4 1 0",
                         c, out_idx0, out_idx1, out_last0, out_none0);
            end
            step();
        end
        in_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (act_out(d) !== exp_out(d)) begin
                fails++;
                $display("[TB] FAIL onehot_idle dut%0d: got %b expected %b", d, act_out(d), exp_out(d));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_vec    = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (act_out(d) !== exp_out(d)) begin
                    fails++;
                    $display("[TB] FAIL random dut%0d cyc%0d: got %b expected %b", d, c, act_out(d), exp_out(d));
                end
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_two_bits();
        test_zero_vector();
        test_stall();
        test_reset_mid_scan();
        test_onehot_ignore();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
